// File: rtl/avmm_pkg.sv
// Shared types for the Avalon-MM command master: the buffered command record
// and the write-sequencer state encoding.
package avmm_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } avmm_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } avmm_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two depth with a registered occupancy count, exposing
// both the head entry and the one behind it so writes can run back-to-back.
import avmm_pkg::*;

module cmd_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             push,
  input  avmm_cmd_t        push_data,
  input  logic             pop,
  output avmm_cmd_t        head,
  output avmm_cmd_t        next_head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  avmm_cmd_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PTR_W'(1)];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avmm_cmd_master.sv
// Drains buffered {addr, data} commands onto an Avalon-MM master write port,
// honouring waitrequest and an optional idle gap between writes.
import avmm_pkg::*;

module avmm_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [7:0]  address,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  avmm_state_t      state;
  avmm_state_t      state_next;
  avmm_cmd_t        head;
  avmm_cmd_t        next_head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             done;
  logic             load_head;
  logic             load_next;
  logic             gap_load;
  logic [3:0]       gap_cnt;

  // Ready comes only from the registered count, gated off while reset is held.
  assign cmd_ready = !rst_in && !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !empty || (state != IDLE);

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (push),
    .push_data ({cmd_addr, cmd_data}),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = WRITE;
      WRITE: begin
        if (!waitrequest) begin
          if (GAP_CYCLES > 0)            state_next = GAP;
          else if (count > CNT_W'(1))    state_next = WRITE;
          else                           state_next = IDLE;
        end
      end
      GAP:   if (gap_cnt == 4'd0) state_next = empty ? IDLE : WRITE;
      default: state_next = IDLE;
    endcase
  end

  // The entry being written stays in the FIFO until it completes, so a
  // back-to-back write loads the entry behind the head.
  always_comb begin
    done      = (state == WRITE) && !waitrequest;
    pop       = done;
    load_head = ((state == IDLE) && !empty) ||
                ((state == GAP) && (gap_cnt == 4'd0) && !empty);
    load_next = done && (GAP_CYCLES == 0) && (count > CNT_W'(1));
    gap_load  = done && (GAP_CYCLES > 0);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      write     <= 1'b0;
      address   <= '0;
      writedata <= '0;
      wr_count  <= '0;
      gap_cnt   <= '0;
    end else begin
      write <= (state_next == WRITE);
      if (load_head)      {address, writedata} <= head;
      else if (load_next) {address, writedata} <= next_head;
      if (done) wr_count <= wr_count + 16'd1;
      if (gap_load)                                gap_cnt <= 4'(GAP_CYCLES - 1);
      else if ((state == GAP) && (gap_cnt != 4'd0)) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: doc/avmm_cmd_master.md
AVMM_CMD_MASTER -- requirements
Module: avmm_cmd_master

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered commands; power of two, 2..16.
REQ-002 Parameter: GAP_CYCLES, 0, idle cycles inserted between consecutive Avalon writes; range 0..15.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst_in  input  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  input  1  upstream command present.
REQ-006 Port: cmd_ready  output  1  block can accept a command this cycle.
REQ-007 Port: cmd_addr  input  8  target register address.
REQ-008 Port: cmd_data  input  32  write data.
REQ-009 Port: address  output  8  Avalon-MM master address; drives the s0 slave.
REQ-010 Port: write  output  1  Avalon-MM write strobe.
REQ-011 Port: writedata  output  32  Avalon-MM write data.
REQ-012 Port: waitrequest  input  1  slave stall; tie to 0 for slaves without waitrequest.
REQ-013 Port: busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-014 Port: wr_count  output  16  number of completed writes since reset.

Function
REQ-015 A command is accepted on any rising edge where cmd_valid && cmd_ready; {cmd_addr, cmd_data} is pushed into the FIFO.
REQ-016 cmd_ready SHALL be 1 exactly when the registered FIFO count < FIFO_DEPTH; it SHALL NOT depend combinationally on waitrequest or on a same-cycle pop.
REQ-017 FIFO order SHALL be strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-018 Simultaneous push and pop SHALL leave the count unchanged and both SHALL take effect.
REQ-019 FSM states: IDLE, WRITE, GAP.
REQ-020 IDLE -> WRITE when the FIFO is non-empty; the FIFO head is loaded into the address/writedata registers on that edge.
REQ-021 In WRITE, write = 1; address and writedata SHALL remain constant while waitrequest = 1.
REQ-022 A write completes on an edge where write && !waitrequest; the FIFO entry is popped and wr_count increments on that edge.
REQ-023 After completion: if GAP_CYCLES > 0 -> GAP; otherwise -> WRITE with the next head loaded if the FIFO is non-empty (back-to-back), or -> IDLE if it is empty.
REQ-024 GAP lasts exactly GAP_CYCLES cycles with write = 0, then -> WRITE if the FIFO is non-empty, else -> IDLE.
REQ-025 Latency: a command accepted into an empty FIFO in IDLE at edge N SHALL produce write = 1 in the cycle after edge N+1.
REQ-026 wr_count SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-027 write SHALL be a registered output, with no combinational path from any input.
REQ-028 A push while the FIFO is full cannot occur because cmd_ready = 0; FIFO contents SHALL stay unchanged.

Reset
REQ-029 On any edge with rst_in = 1, the following SHALL take effect: FSM -> IDLE, FIFO emptied, pointers = 0, wr_count = 0, write = 0, address = 0, writedata = 0, GAP counter = 0.
REQ-030 During reset, cmd_ready SHALL read 0; it SHALL read 1 from the first cycle after rst_in falls.
REQ-031 Reset during WRITE SHALL abort the transfer: write = 0 after that edge, and pending commands are discarded without being issued.

Structure
REQ-032 A shared package avmm_pkg SHALL hold: typedef avmm_cmd_t {addr[7:0], data[31:0]}, the FSM state enum, and ADDR_W = 8 and DATA_W = 32.
REQ-033 The FIFO SHALL be a sub-module cmd_fifo (parameterised depth, push/pop/full/empty/count); FSM and counters stay in avmm_cmd_master.

Verification
REQ-034 The bench SHALL cover this scenario: reset, then one command {0x04, 0xDEADBEEF} with waitrequest = 0 -> one write pulse of exactly 1 cycle, address 0x04, writedata 0xDEADBEEF; wr_count = 1 afterwards.
REQ-035 The bench SHALL cover this scenario: 5 commands pushed back-to-back with FIFO_DEPTH = 4 while waitrequest = 1 -> cmd_ready low after the 4th accept; address/writedata stable throughout the stall; after release, 5 writes issued in order.
REQ-036 The bench SHALL cover this scenario: GAP_CYCLES = 2, 3 queued commands -> write high 1 cycle, low 2 cycles, repeated; wr_count = 3.
REQ-037 The bench SHALL cover this scenario: waitrequest held high 3 cycles during a write -> write high for 4 cycles, single pop, wr_count increments by 1.
REQ-038 The bench SHALL cover this scenario: rst_in asserted mid-WRITE with 2 commands queued -> write = 0 next cycle, busy = 0, wr_count = 0, no further writes after reset is released.
REQ-039 The bench SHALL cover this scenario: wr_count preloaded via 65536 completed writes (fast-forward allowed) -> wr_count reads 0x0000.
